// File: rtl/alu_flags_writeback_pkg.sv
// Shared microarchitecture definitions: ALU op codes, branch conditions, flag bit positions.
// No logic; types and constants only.
// Imported by the flag/writeback block, its interface and the condition evaluator.
package alu_flags_writeback_pkg;

    // ALU operation codes, shared with the ALU itself.
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    // Branch conditions evaluated against the status register.
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_NN     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_t;

    // Bit positions inside the {N,C,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

    // Arithmetic ops produce a meaningful carry; logic ops do not.
    function automatic logic is_arith(input alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_flags_writeback_if.sv
// Bundle between the ALU/control side and the flag + writeback block.
// slave  = the flag/writeback block; master = the surrounding environment (ALU, control, writeback).
// Carries exec flags, flag overrides, branch condition, result valid/ready handshake and status.
interface alu_flags_writeback_if
    import alu_flags_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    // ALU execute side
    logic                  alu_exec;
    alu_op_t               alu_op;
    logic                  alu_zero;
    logic                  alu_carry;
    logic                  alu_negative;
    logic [DATA_WIDTH-1:0] alu_result;
    // Control-unit flag overrides and branch query
    logic                  flag_load;
    logic [FLAG_W-1:0]     flag_bus_in;
    logic                  flag_clear;
    cond_t                 cond_sel;
    logic                  branch_taken;
    logic [FLAG_W-1:0]     flags_out;
    // Writeback handshake
    logic [DATA_WIDTH-1:0] result_data;
    logic                  result_valid;
    logic                  result_ready;
    // Status
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  alu_exec, alu_op, alu_zero, alu_carry, alu_negative, alu_result,
        input  flag_load, flag_bus_in, flag_clear, cond_sel, result_ready,
        output branch_taken, flags_out, result_data, result_valid, busy, overrun
    );

    modport master (
        output alu_exec, alu_op, alu_zero, alu_carry, alu_negative, alu_result,
        output flag_load, flag_bus_in, flag_clear, cond_sel, result_ready,
        input  branch_taken, flags_out, result_data, result_valid, busy, overrun
    );

endinterface

// File: rtl/alu_flags_writeback_cond_eval.sv
// Branch condition evaluator over an {N,C,Z} flag vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_flags {N,C,Z}, i_cond_sel condition code, o_taken condition holds.
module alu_flags_writeback_cond_eval
    import alu_flags_writeback_pkg::*;
(
    input  logic [FLAG_W-1:0] i_flags,
    input  cond_t             i_cond_sel,
    output logic              o_taken
);

    logic w_z;
    logic w_c;
    logic w_n;

    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_n = i_flags[FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        unique case (i_cond_sel)
            COND_ALWAYS: o_taken = 1'b1;
            COND_Z:      o_taken = w_z;
            COND_NZ:     o_taken = !w_z;
            COND_C:      o_taken = w_c;
            COND_NC:     o_taken = !w_c;
            COND_N:      o_taken = w_n;
            COND_NN:     o_taken = !w_n;
            COND_NEVER:  o_taken = 1'b0;
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_writeback.sv
// ALU neighbour: holds the {N,C,Z} status register, registers branch decisions and hands
// ALU results to writeback. Latency: flags 1 edge after exec, result_valid 2 edges after exec.
// Backpressure: result_ready low holds the output; one more result can wait, a further exec is dropped (overrun).
// Ports: clk, reset (async active-low), bus = alu_flags_writeback_if.slave carrying all ALU/control/writeback signals.
module alu_flags_writeback
    import alu_flags_writeback_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter bit FLAG_UPDATE_LOGIC_C = 1'b0
)(
    input  logic                  clk,
    input  logic                  reset,
    alu_flags_writeback_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FLAG_W-1:0]     r_flags;
    logic                  r_branch_taken;
    logic                  r_overrun;
    // r_pending: an exec was accepted whose result has not yet reached the output register.
    logic                  r_pending;
    // The ALU's latched result is only guaranteed the cycle after exec, so a pending
    // result that cannot move to the output yet is parked in the skid register.
    logic                  r_skid_full;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [DATA_WIDTH-1:0] r_result_data;
    logic                  r_result_valid;

    // ------------------------------------------------------------------
    // Handshake / acceptance
    // ------------------------------------------------------------------
    logic                  w_busy;
    logic                  w_exec_acc;
    logic                  w_slot_free;
    logic                  w_capture;
    logic                  w_skid_load;
    logic [DATA_WIDTH-1:0] w_cap_src;

    // Output is stalled and a second result is already queued: nowhere for a third.
    assign w_busy      = r_result_valid && !bus.result_ready && r_pending;
    assign w_exec_acc  = bus.alu_exec && !w_busy;
    // Output register can take new data this edge (empty, or being consumed).
    assign w_slot_free = !r_result_valid || bus.result_ready;
    assign w_capture   = r_pending && w_slot_free;
    // First cycle after exec with a stalled output: grab the ALU result before it moves on.
    assign w_skid_load = r_pending && !r_skid_full && !w_slot_free;
    assign w_cap_src   = r_skid_full ? r_skid_data : bus.alu_result;

    // ------------------------------------------------------------------
    // Flag update
    // ------------------------------------------------------------------
    logic [FLAG_W-1:0] w_exec_flags;
    logic [FLAG_W-1:0] w_flags_nxt;
    logic              w_taken;

    always_comb begin
        w_exec_flags         = r_flags;
        w_exec_flags[FLAG_Z] = bus.alu_zero;
        w_exec_flags[FLAG_N] = bus.alu_negative;
        if (is_arith(bus.alu_op)) begin
            w_exec_flags[FLAG_C] = bus.alu_carry;
        end else if (FLAG_UPDATE_LOGIC_C) begin
            w_exec_flags[FLAG_C] = 1'b0;
        end
    end

    // Clear beats load beats exec; a losing exec still feeds the result path.
    always_comb begin
        w_flags_nxt = r_flags;
        if (bus.flag_clear) begin
            w_flags_nxt = '0;
        end else if (bus.flag_load) begin
            w_flags_nxt = bus.flag_bus_in;
        end else if (w_exec_acc) begin
            w_flags_nxt = w_exec_flags;
        end
    end

    // Branch decision uses the flags as they will be after this edge.
    alu_flags_writeback_cond_eval u_cond_eval (
        .i_flags    (w_flags_nxt),
        .i_cond_sel (bus.cond_sel),
        .o_taken    (w_taken)
    );

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags        <= '0;
            r_branch_taken <= 1'b0;
            r_overrun      <= 1'b0;
            r_pending      <= 1'b0;
            r_skid_full    <= 1'b0;
            r_skid_data    <= '0;
            r_result_data  <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_flags        <= w_flags_nxt;
            r_branch_taken <= w_taken;

            if (bus.alu_exec && w_busy) begin
                r_overrun <= 1'b1;
            end

            if (w_capture) begin
                r_result_data  <= w_cap_src;
                r_result_valid <= 1'b1;
            end else if (r_result_valid && bus.result_ready) begin
                r_result_valid <= 1'b0;
            end

            if (w_skid_load) begin
                r_skid_data <= bus.alu_result;
                r_skid_full <= 1'b1;
            end else if (w_capture) begin
                r_skid_full <= 1'b0;
            end

            // A new exec may be accepted on the same edge the previous one moves out.
            if (w_exec_acc) begin
                r_pending <= 1'b1;
            end else if (w_capture) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.flags_out    = r_flags;
    assign bus.branch_taken = r_branch_taken;
    assign bus.result_data  = r_result_data;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = w_busy;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_alu_flags_writeback.sv
// Randomised + directed bench for alu_flags_writeback with a queue-based reference model.
// Two DUTs share stimulus: default C handling and FLAG_UPDATE_LOGIC_C=1.
// A separate monitor pops expected writeback data whenever a transfer is presented.
module tb_alu_flags_writeback;
    import alu_flags_writeback_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_flags_writeback_if #(.DATA_WIDTH(DW)) bus0 ();
    alu_flags_writeback_if #(.DATA_WIDTH(DW)) bus1 ();

    alu_flags_writeback #(.DATA_WIDTH(DW), .FLAG_UPDATE_LOGIC_C(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    alu_flags_writeback #(.DATA_WIDTH(DW), .FLAG_UPDATE_LOGIC_C(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    assign bus1.alu_exec     = bus0.alu_exec;
    assign bus1.alu_op       = bus0.alu_op;
    assign bus1.alu_zero     = bus0.alu_zero;
    assign bus1.alu_carry    = bus0.alu_carry;
    assign bus1.alu_negative = bus0.alu_negative;
    assign bus1.alu_result   = bus0.alu_result;
    assign bus1.flag_load    = bus0.flag_load;
    assign bus1.flag_bus_in  = bus0.flag_bus_in;
    assign bus1.flag_clear   = bus0.flag_clear;
    assign bus1.cond_sel     = bus0.cond_sel;
    assign bus1.result_ready = bus0.result_ready;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } ent_t;

    ent_t          mq[$];     // results held by the block, oldest first
    logic [DW-1:0] sb[$];     // expected writeback data in order
    logic [2:0]    m_flags0, m_flags1;
    logic          m_branch0, m_branch1, m_overrun;
    logic [DW-1:0] alu_latch;
    int            k;         // index of the next clock edge
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // flags vector is {N,C,Z}
    function automatic logic cond_true(input logic [2:0] f, input logic [2:0] cs);
        case (cs)
            3'd0: return 1'b1;
            3'd1: return f[0];
            3'd2: return !f[0];
            3'd3: return f[1];
            3'd4: return !f[1];
            3'd5: return f[2];
            3'd6: return !f[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] flags_after(input logic [2:0] f, input bit clr_c,
                                               input logic acc, input logic [1:0] op,
                                               input logic z, input logic c, input logic n,
                                               input logic ld, input logic [2:0] fb,
                                               input logic clr);
        logic new_c;
        if (clr) return 3'b000;
        if (ld) return fb;
        if (!acc) return f;
        if (op < 2) new_c = c;
        else if (clr_c) new_c = 1'b0;
        else new_c = f[1];
        return {n, new_c, z};
    endfunction

    // A result becomes visible on the second edge after its exec at the earliest.
    function automatic logic m_valid();
        return (mq.size() > 0) && (mq[0].cyc + 1 < k);
    endfunction

    // One clock cycle: drive inputs, advance the model across the edge, check outputs.
    // Called just after a rising edge.
    task automatic step(input logic ex, input logic [1:0] op, input logic z, input logic c,
                        input logic n, input logic [DW-1:0] d, input logic ld,
                        input logic [2:0] fb, input logic clr, input logic [2:0] cs,
                        input logic rdy);
        logic vis, busy_m, acc;
        bus0.alu_exec     = ex;
        bus0.alu_op       = alu_op_t'(op);
        bus0.alu_zero     = z;
        bus0.alu_carry    = c;
        bus0.alu_negative = n;
        bus0.flag_load    = ld;
        bus0.flag_bus_in  = fb;
        bus0.flag_clear   = clr;
        bus0.cond_sel     = cond_t'(cs);
        bus0.result_ready = rdy;
        #1;
        vis    = m_valid();
        busy_m = vis && !rdy && (mq.size() == 2);
        acc    = ex && !busy_m;
        chk("busy", 32'(bus0.busy), 32'(busy_m));

        m_flags0  = flags_after(m_flags0, 1'b0, acc, op, z, c, n, ld, fb, clr);
        m_flags1  = flags_after(m_flags1, 1'b1, acc, op, z, c, n, ld, fb, clr);
        m_branch0 = cond_true(m_flags0, cs);
        m_branch1 = cond_true(m_flags1, cs);
        if (ex && !acc) m_overrun = 1'b1;
        if (vis && rdy) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{d: d, cyc: k});
            sb.push_back(d);
        end
        k++;

        @(posedge clk);
        #1;
        // the ALU latches on every exec, whether or not this block accepts it
        if (ex) alu_latch = d;
        bus0.alu_result = alu_latch;
        chk("flags_def", 32'(bus0.flags_out), 32'(m_flags0));
        chk("flags_clrc", 32'(bus1.flags_out), 32'(m_flags1));
        chk("branch_def", 32'(bus0.branch_taken), 32'(m_branch0));
        chk("branch_clrc", 32'(bus1.branch_taken), 32'(m_branch1));
        chk("overrun", 32'(bus0.overrun), 32'(m_overrun));
        chk("result_valid", 32'(bus0.result_valid), 32'(m_valid()));
    endtask

    task automatic idle(input logic rdy, input logic [2:0] cs);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, cs, rdy);
    endtask

    task automatic model_reset();
        m_flags0  = 3'b000;
        m_flags1  = 3'b000;
        m_branch0 = 1'b0;
        m_branch1 = 1'b0;
        m_overrun = 1'b0;
        mq.delete();
        sb.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus0.result_valid && bus0.result_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual=%0h expected=no_result", bus0.result_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", 32'(bus0.result_data), 32'(e));
                    chk("wb_data_clrc", 32'(bus1.result_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bus0.alu_exec     = 1'b0;
        bus0.alu_op       = ALU_ADD;
        bus0.alu_zero     = 1'b0;
        bus0.alu_carry    = 1'b0;
        bus0.alu_negative = 1'b0;
        bus0.alu_result   = '0;
        bus0.flag_load    = 1'b0;
        bus0.flag_bus_in  = 3'b000;
        bus0.flag_clear   = 1'b0;
        bus0.cond_sel     = COND_ALWAYS;
        bus0.result_ready = 1'b0;
        alu_latch = '0;
        k = 0;
        model_reset();

        #12;
        chk("rst_flags", 32'(bus0.flags_out), 32'd0);
        chk("rst_valid", 32'(bus0.result_valid), 32'd0);
        chk("rst_branch", 32'(bus0.branch_taken), 32'd0);
        chk("rst_overrun", 32'(bus0.overrun), 32'd0);
        chk("rst_data", 32'(bus0.result_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD: Z=1 C=1 N=0, result 00; branch on Z
        step(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 3'd1, 1'b1);
        chk("add_flags", 32'(bus0.flags_out), 32'h3);
        chk("add_branch_z", 32'(bus0.branch_taken), 32'd1);
        idle(1'b1, 3'd1);
        // AND: Z=0 N=1 C=0; branch on NC
        step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 3'b000, 1'b0, 3'd4, 1'b1);
        chk("and_flags_def", 32'(bus0.flags_out), 32'h6);
        chk("and_flags_clrc", 32'(bus1.flags_out), 32'h4);
        chk("and_branch_nc", 32'(bus0.branch_taken), 32'd0);
        idle(1'b1, 3'd0);
        // SUB with same-edge flag_load, then with flag_clear as well
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'b100, 1'b0, 3'd5, 1'b1);
        chk("load_wins", 32'(bus0.flags_out), 32'h4);
        step(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'b100, 1'b1, 3'd2, 1'b1);
        chk("clear_wins", 32'(bus0.flags_out), 32'h0);
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);

        // Stall: three execs with ready low; third dropped
        step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
        chk("stall_hold", 32'(bus0.result_data), 32'h11);
        chk("stall_overrun", 32'(bus0.overrun), 32'd1);
        idle(1'b0, 3'd0);
        chk("stall_hold2", 32'(bus0.result_data), 32'h11);
        idle(1'b1, 3'd0);
        chk("stall_next", 32'(bus0.result_data), 32'h22);
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);

        // Stream four back-to-back ops (fresh reset first so overrun is clear)
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'(8'hA0 + i), 1'b0, 3'b000, 1'b0, 3'd0, 1'b1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 3'd0);
        chk("stream_overrun", 32'(bus0.overrun), 32'd0);

        // Reset mid-capture: one result on the output, another pending
        step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_flags", 32'(bus0.flags_out), 32'd0);
        chk("mid_rst_valid", 32'(bus0.result_valid), 32'd0);
        chk("mid_rst_data", 32'(bus0.result_data), 32'd0);
        chk("mid_rst_branch", 32'(bus0.branch_taken), 32'd0);
        chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
        model_reset();
        bus0.alu_exec = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1, 3'd0);
        idle(1'b1, 3'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 60,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 8,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 5,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 55);
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 3'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
